// File: rtl/pipe_pkg.sv
// Shared constants and types for the pipeline stage register and its skid entry.
package pipe_pkg;

  // All-zero instruction word shown on ir_out whenever the stage holds nothing.
  localparam logic [31:0] NOP = 32'h0000_0000;

  // Default PC loaded into the held PC fields by reset.
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

  // Exception code carried alongside each instruction.
  typedef logic [4:0] exc_code_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Single skid entry for pipe_stage_reg. It captures an item when the main register
// is busy and hands it back once the main register frees up.
// With PIPE_STAGE_EXC_EN defined the entry also stores the exception code and the
// branch-delay flag; otherwise those outputs are tied to zero and nothing is stored.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int unsigned IR_W = 32,
  parameter int unsigned PC_W = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            load_i,
  input  logic            pop_i,
  input  logic [IR_W-1:0] ir_i,
  input  logic [PC_W-1:0] pc_i,
  input  exc_code_t       exc_i,
  input  logic            bd_i,
  output logic            valid_o,
  output logic [IR_W-1:0] ir_o,
  output logic [PC_W-1:0] pc_o,
  output exc_code_t       exc_o,
  output logic            bd_o
);

  logic            valid_q, valid_d;
  logic [IR_W-1:0] ir_q, ir_d;
  logic [PC_W-1:0] pc_q, pc_d;

  // Occupancy and payload next state; load and pop are never asserted together.
  always_comb begin
    valid_d = valid_q;
    ir_d    = ir_q;
    pc_d    = pc_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      ir_d    = ir_i;
      pc_d    = pc_i;
    end else if (pop_i) begin
      valid_d = 1'b0;
    end
  end

  // Entry state; reset empties it without waiting for a clock.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      ir_q    <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      ir_q    <= ir_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign ir_o    = ir_q;
  assign pc_o    = pc_q;

`ifdef PIPE_STAGE_EXC_EN
  exc_code_t exc_q, exc_d;
  logic      bd_q, bd_d;

  // Side-band fields follow the same load rule as the payload.
  always_comb begin
    exc_d = exc_q;
    bd_d  = bd_q;
    if (!flush_i && load_i) begin
      exc_d = exc_i;
      bd_d  = bd_i;
    end
  end

  // Side-band storage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      exc_q <= '0;
      bd_q  <= 1'b0;
    end else begin
      exc_q <= exc_d;
      bd_q  <= bd_d;
    end
  end

  assign exc_o = exc_q;
  assign bd_o  = bd_q;
`else
  logic unused_exc;
  assign unused_exc = ^{exc_i, bd_i};
  assign exc_o      = '0;
  assign bd_o       = 1'b0;
`endif

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a one-entry skid buffer.
// The main entry drives the outputs; the skid entry absorbs one item when the
// downstream stalls so that in_ready can come straight from a flop.
// PC+4 and PC+8 are computed when an item loads into the main entry and held.
// Optional feature macro PIPE_STAGE_EXC_EN: carries exc_in/bd_in with each item.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned     IR_W     = 32,
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IR_W-1:0] ir_in,
  input  logic [PC_W-1:0] pc_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [IR_W-1:0] ir_out,
  output logic [PC_W-1:0] pc_out,
  output logic [PC_W-1:0] pc4_out,
  output logic [PC_W-1:0] pc8_out,
  output logic [1:0]      occ,
  input  exc_code_t       exc_in,
  input  logic            bd_in,
  output exc_code_t       exc_out,
  output logic            bd_out
);

  logic            main_valid_q, main_valid_d;
  logic [IR_W-1:0] ir_q, ir_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc4_q, pc4_d;
  logic [PC_W-1:0] pc8_q, pc8_d;

  logic            skid_valid;
  logic [IR_W-1:0] skid_ir;
  logic [PC_W-1:0] skid_pc;
  exc_code_t       skid_exc;
  logic            skid_bd;

  logic            accept;
  logic            rel;
  logic            main_free;
  logic            main_load;
  logic            main_clear;
  logic            skid_load;
  logic            skid_pop;
  logic [PC_W-1:0] load_pc;

  // Handshake decode. Flush overrides every movement in the same cycle.
  always_comb begin
    accept     = in_valid & in_ready;
    rel        = main_valid_q & out_ready;
    main_free  = ~main_valid_q | rel;
    main_load  = ~flush & main_free & (skid_valid | accept);
    main_clear = flush | (main_free & ~skid_valid & ~accept);
    skid_load  = ~flush & accept & ~main_free;
    skid_pop   = ~flush & main_free & skid_valid;
    load_pc    = skid_valid ? skid_pc : pc_in;
  end

  // Main entry next state; the skid item always wins over a new input to keep order.
  always_comb begin
    main_valid_d = main_valid_q;
    ir_d         = ir_q;
    pc_d         = pc_q;
    pc4_d        = pc4_q;
    pc8_d        = pc8_q;
    if (main_load) begin
      main_valid_d = 1'b1;
      ir_d         = skid_valid ? skid_ir : ir_in;
      pc_d         = load_pc;
      pc4_d        = load_pc + PC_W'(4);
      pc8_d        = load_pc + PC_W'(8);
    end else if (main_clear) begin
      // PC fields hold; only the instruction is replaced by a bubble.
      main_valid_d = 1'b0;
      ir_d         = IR_W'(NOP);
    end
  end

  // Main entry state with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      ir_q         <= IR_W'(NOP);
      pc_q         <= RESET_PC;
      pc4_q        <= RESET_PC + PC_W'(4);
      pc8_q        <= RESET_PC + PC_W'(8);
    end else begin
      main_valid_q <= main_valid_d;
      ir_q         <= ir_d;
      pc_q         <= pc_d;
      pc4_q        <= pc4_d;
      pc8_q        <= pc8_d;
    end
  end

  pipe_skid_buf #(
    .IR_W (IR_W),
    .PC_W (PC_W)
  ) u_skid (
    .clk_i   (clk),
    .rst_i   (reset),
    .flush_i (flush),
    .load_i  (skid_load),
    .pop_i   (skid_pop),
    .ir_i    (ir_in),
    .pc_i    (pc_in),
    .exc_i   (exc_in),
    .bd_i    (bd_in),
    .valid_o (skid_valid),
    .ir_o    (skid_ir),
    .pc_o    (skid_pc),
    .exc_o   (skid_exc),
    .bd_o    (skid_bd)
  );

  // Ready is the complement of a flop, so a full stage never accepts even if it drains now.
  assign in_ready  = ~skid_valid;
  assign out_valid = main_valid_q;
  assign ir_out    = ir_q;
  assign pc_out    = pc_q;
  assign pc4_out   = pc4_q;
  assign pc8_out   = pc8_q;
  assign occ       = {1'b0, main_valid_q} + {1'b0, skid_valid};

`ifdef PIPE_STAGE_EXC_EN
  exc_code_t exc_q, exc_d;
  logic      bd_q, bd_d;

  // Side-band fields move with the item and clear with the bubble.
  always_comb begin
    exc_d = exc_q;
    bd_d  = bd_q;
    if (main_load) begin
      exc_d = skid_valid ? skid_exc : exc_in;
      bd_d  = skid_valid ? skid_bd : bd_in;
    end else if (main_clear) begin
      exc_d = '0;
      bd_d  = 1'b0;
    end
  end

  // Side-band storage for the main entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exc_q <= '0;
      bd_q  <= 1'b0;
    end else begin
      exc_q <= exc_d;
      bd_q  <= bd_d;
    end
  end

  assign exc_out = exc_q;
  assign bd_out  = bd_q;
`else
  logic unused_exc;
  assign unused_exc = ^{exc_in, bd_in, skid_exc, skid_bd};
  assign exc_out    = '0;
  assign bd_out     = 1'b0;
`endif

endmodule
